uart_tx_fifo: RTL and testbench

- Transmit buffer sitting directly upstream of the UART block's TX interface, in the system 'clk' domain.
- Accepts bytes from the bus side into a DEPTH-entry FIFO.
- Drains the FIFO one byte at a time into the UART's tx_data/tx_valid/tx_busy handshake, so software does not poll tx_busy per byte.
- Holds tx_data stable for the whole transmission, because the UART's serializer samples tx_data directly.

---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that drains into the UART tx_data/tx_valid/tx_busy handshake.
// Ports: clk/rst; wr_data/wr_en/flush/enable/overflow_clr in; full/almost_full/level/overflow/idle out; tx_data/tx_valid out, tx_busy in.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  input  logic                  enable,
  input  logic                  overflow_clr,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  idle,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int PW    = DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] lvl;
  logic          ovf;
  logic [7:0]    data_q;

  logic          wr_ok;
  logic          wr_drop;
  logic          start;
  logic          pop;

  // Status flags come only from registered level/state.
  assign full        = (lvl == LW'(DEPTH));
  assign almost_full = (lvl >= LW'(AF_THRESH));
  assign level       = lvl;
  assign overflow    = ovf;
  assign idle        = (lvl == '0) && (state == S_IDLE);
  assign tx_data     = data_q;

  // A flush swallows a concurrent write without flagging overflow.
  assign wr_ok   = wr_en & ~full & ~flush;
  assign wr_drop = wr_en &  full & ~flush;

  // Conditions for launching the next byte from IDLE.
  assign start = (state == S_IDLE) && (lvl != '0) &&
                 enable && !tx_busy && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SEND;
      end
      S_SEND: begin
        state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy) state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    tx_valid = 1'b0;
    pop      = 1'b0;
    unique case (state)
      S_IDLE:    pop      = start;
      S_SEND:    tx_valid = 1'b1;
      S_WAIT_HI: tx_valid = 1'b0;
      S_WAIT_LO: tx_valid = 1'b0;
      default:   tx_valid = 1'b0;
    endcase
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and level.  Level is kept separately so
  // full and empty never need pointer comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      lvl    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_ok, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  // The serializer samples tx_data directly, so it
  // only changes when the next byte is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 8'h00;
    end else if (pop) begin
      data_q <= mem[rd_ptr];
    end
  end

  // Sticky overflow; a new drop beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (wr_drop) begin
      ovf <= 1'b1;
    end else if (overflow_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed + randomized checks of uart_tx_fifo
// against a UART responder model and expected byte order.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       flush;
  logic       enable;
  logic       overflow_clr;
  logic       full;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;
  logic       idle;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(4), .AF_THRESH(12)) dut (
    .clk(clk), .rst(rst),
    .wr_data(wr_data), .wr_en(wr_en),
    .flush(flush), .enable(enable),
    .overflow_clr(overflow_clr),
    .full(full), .almost_full(almost_full),
    .level(level), .overflow(overflow),
    .idle(idle), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_busy(tx_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  // UART responder model
  logic [7:0] rx_q [$];
  logic [7:0] cap = 8'h00;
  int  cyc = 0;
  int  cnt = 0;
  int  nxt_len = 4;
  int  prev_len = 0;
  int  prev_cyc = 0;
  bit  have_prev = 1'b0;
  int  stab_err = 0;
  int  proto_err = 0;
  int  gap_err = 0;
  int  busy_len = 4;
  bit  rand_busy = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    nxt_len <= rand_busy ? int'($urandom_range(1, 5)) : busy_len;
    if (rst) begin
      tx_busy <= 1'b0;
      cnt <= 0;
      have_prev <= 1'b0;
    end else if (tx_valid) begin
      if (tx_busy) begin
        proto_err <= proto_err + 1;
      end else begin
        rx_q.push_back(tx_data);
        cap <= tx_data;
        tx_busy <= 1'b1;
        cnt <= nxt_len;
        if (have_prev && (cyc - prev_cyc) < prev_len + 3)
          gap_err <= gap_err + 1;
        have_prev <= 1'b1;
        prev_cyc <= cyc;
        prev_len <= nxt_len;
      end
    end else if (tx_busy) begin
      if (tx_data !== cap) stab_err <= stab_err + 1;
      if (cnt <= 1) tx_busy <= 1'b0;
      else cnt <= cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(int idx);
    if (idx < rx_q.size()) return {24'h0, rx_q[idx]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic wait_rx(int n, string tag);
    int k = 0;
    while (rx_q.size() < n && k < 2000) begin
      tick();
      k++;
    end
    chk(tag, 32'(rx_q.size() >= n), 1);
  endtask

  task automatic wait_idle(string tag);
    int k = 0;
    while (!(idle && !tx_busy) && k < 2000) begin
      tick();
      k++;
    end
    chk(tag, {30'h0, idle, tx_busy}, 32'h2);
  endtask

  task automatic put(logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  int  base;
  int  k;
  int  written;
  bit  seen;

  initial begin
    rst = 1'b1;
    wr_data = 8'h00;
    wr_en = 1'b0;
    flush = 1'b0;
    enable = 1'b0;
    overflow_clr = 1'b0;
    tick();
    tick();
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_idle", idle, 1);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 8'h00);
    rst = 1'b0;

    // single byte latency
    busy_len = 20;
    enable = 1'b1;
    tick();
    base = rx_q.size();
    put(8'h41);
    chk("t1_lvl1", level, 1);
    chk("t1_txv0", tx_valid, 0);
    tick();
    chk("t1_txv", tx_valid, 1);
    chk("t1_txd", tx_data, 8'h41);
    chk("t1_lvl0", level, 0);
    chk("t1_busy", idle, 0);
    wait_idle("t1_idle");
    chk("t1_cnt", rx_q.size() - base, 1);
    chk("t1_rx", rx_at(base), 8'h41);
    chk("t1_hold", tx_data, 8'h41);

    // fill to full with the drain held off
    enable = 1'b0;
    rand_busy = 1'b1;
    base = rx_q.size();
    for (int i = 0; i < 16; i++) begin
      put(8'(i));
      chk("t2_lvl", level, i + 1);
      chk("t2_full", full, 32'(i + 1 == 16));
      chk("t2_af", almost_full, 32'(i + 1 >= 12));
    end
    put(8'hFF);
    chk("t2_ovf", overflow, 1);
    chk("t2_lvl16", level, 16);
    enable = 1'b1;
    wait_rx(base + 16, "t2_drain");
    for (int i = 0; i < 16; i++)
      chk("t2_order", rx_at(base + i), i);
    wait_idle("t2_idle");
    chk("t2_noff", rx_q.size() - base, 16);
    chk("t2_ovf_st", overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t2_ovf_clr", overflow, 0);

    // paced random stream through pointer wrap
    base = rx_q.size();
    written = 0;
    k = 0;
    while (written < 40 && k < 4000) begin
      if ((written - (rx_q.size() - base)) < 15 &&
          $urandom_range(0, 1) == 1) begin
        wr_en = 1'b1;
        wr_data = 8'h80 + 8'(written);
        written++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      k++;
    end
    wr_en = 1'b0;
    chk("t3_written", written, 40);
    wait_rx(base + 40, "t3_drain");
    for (int i = 0; i < 40; i++)
      chk("t3_order", rx_at(base + i), 8'h80 + i);
    chk("t3_ovf", overflow, 0);
    wait_idle("t3_idle");

    // flush while a byte is in flight
    rand_busy = 1'b0;
    busy_len = 20;
    tick();
    base = rx_q.size();
    put(8'h55);
    k = 0;
    while (!tx_valid && k < 10) begin
      tick();
      k++;
    end
    chk("t4_txv", tx_valid, 1);
    for (int i = 0; i < 5; i++) put(8'hA0 + 8'(i));
    chk("t4_lvl5", level, 5);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    chk("t4_lvl0", level, 0);
    chk("t4_ovf", overflow, 0);
    chk("t4_txd", tx_data, 8'h55);
    chk("t4_inflt", idle, 0);
    wait_idle("t4_idle");
    for (int i = 0; i < 30; i++) tick();
    chk("t4_cnt", rx_q.size() - base, 1);
    chk("t4_rx", rx_at(base), 8'h55);
    chk("t4_lvl", level, 0);

    // drop + clear + pop in one cycle
    enable = 1'b0;
    rand_busy = 1'b1;
    base = rx_q.size();
    for (int i = 0; i < 16; i++) put(8'hD0 + 8'(i));
    chk("t5_full", full, 1);
    wr_en = 1'b1;
    wr_data = 8'h77;
    overflow_clr = 1'b1;
    enable = 1'b1;
    tick();
    wr_en = 1'b0;
    overflow_clr = 1'b0;
    chk("t5_ovf", overflow, 1);
    chk("t5_lvl", level, 15);
    chk("t5_full0", full, 0);
    chk("t5_txv", tx_valid, 1);
    chk("t5_txd", tx_data, 8'hD0);
    wait_rx(base + 16, "t5_drain");
    for (int i = 0; i < 16; i++)
      chk("t5_order", rx_at(base + i), 8'hD0 + i);
    wait_idle("t5_idle");
    chk("t5_cnt", rx_q.size() - base, 16);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t5_clr", overflow, 0);

    // write + pop at level 15
    enable = 1'b0;
    base = rx_q.size();
    for (int i = 0; i < 15; i++) put(8'hC0 + 8'(i));
    chk("t6_lvl15", level, 15);
    wr_en = 1'b1;
    wr_data = 8'hCF;
    enable = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t6_lvl", level, 15);
    chk("t6_full", full, 0);
    chk("t6_txv", tx_valid, 1);
    chk("t6_txd", tx_data, 8'hC0);
    wait_rx(base + 16, "t6_drain");
    for (int i = 0; i < 16; i++)
      chk("t6_order", rx_at(base + i), 8'hC0 + i);
    wait_idle("t6_idle");
    chk("t6_ovf", overflow, 0);

    // reset in WAIT_LO with 3 queued
    rand_busy = 1'b0;
    busy_len = 20;
    tick();
    base = rx_q.size();
    for (int i = 0; i < 4; i++) put(8'hB0 + 8'(i));
    chk("t7_lvl3", level, 3);
    chk("t7_busy", tx_busy, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_lvl", level, 0);
    chk("t7_txv", tx_valid, 0);
    chk("t7_txd", tx_data, 8'h00);
    chk("t7_idle", idle, 1);
    chk("t7_full", full, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tx_valid) seen = 1'b1;
    end
    chk("t7_novalid", seen, 0);
    chk("t7_cnt", rx_q.size() - base, 1);
    chk("t7_rx", rx_at(base), 8'hB0);

    chk("stable", stab_err, 0);
    chk("proto", proto_err, 0);
    chk("gap", gap_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
